ecall_uart_tx: RTL and testbench

//   Host-side responder for the CPU ecall port: captures each 32-bit ecall word strobed by the core.

---
 rtl/ecall_uart_tx_pkg.sv | 19 +
 rtl/ecall_uart_tx_byte.sv | 104 ++++++++++
 rtl/ecall_uart_tx.sv | 108 ++++++++++
 tb/tb_ecall_uart_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ecall_uart_tx_pkg.sv
// Shared definitions for the ecall UART transmitter: FSM encoding, default bit time, line levels.
// Parity frame option is selected per build with `ECALL_UART_PARITY_EN.
package ecall_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 434;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/ecall_uart_tx_byte.sv
// One-byte UART serialiser: START, 8 data bits LSB first, optional even parity (`ECALL_UART_PARITY_EN), STOP.
// Latency: o_tx reflects the current state one cycle later; every bit lasts CLKS_PER_BIT cycles.
// Backpressure: accepts i_valid while idle or in the final stop-bit cycle (o_done), so bytes chain gap-free.
module ecall_uart_tx_byte
    import ecall_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_idle,
    output logic       o_done,
    output logic       o_tx
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_t state, state_nxt;
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  byte_reg, byte_reg_nxt;
    logic        tx_lvl;
    logic        bit_last;

    assign bit_last = (bit_cnt == CNT_LAST);
    assign o_idle   = (state == ST_IDLE);
    assign o_done   = (state == ST_STOP) && bit_last;

    always_comb begin
        state_nxt    = state;
        bit_idx_nxt  = bit_idx;
        byte_reg_nxt = byte_reg;
        bit_cnt_nxt  = (state == ST_IDLE || bit_last) ? 16'd0 : bit_cnt + 16'd1;
        tx_lvl       = UART_IDLE_LVL;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    state_nxt    = ST_START;
                    byte_reg_nxt = i_byte;
                end
            end
            ST_START: begin
                tx_lvl = UART_START_LVL;
                if (bit_last) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                tx_lvl = byte_reg[bit_idx];
                if (bit_last) begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef ECALL_UART_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef ECALL_UART_PARITY_EN
            ST_PARITY: begin
                tx_lvl = ^byte_reg;
                if (bit_last) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_lvl = UART_STOP_LVL;
                // Taking the next byte here keeps frames of a word contiguous.
                if (bit_last) begin
                    if (i_valid) begin
                        state_nxt    = ST_START;
                        byte_reg_nxt = i_byte;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            byte_reg <= 8'd0;
            o_tx     <= UART_IDLE_LVL;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_reg <= byte_reg_nxt;
            o_tx     <= tx_lvl;
        end
    end

endmodule

// File: rtl/ecall_uart_tx.sv
// Ecall word FIFO feeding a UART: each 32-bit word leaves as 4 frames, byte 0 first (`ECALL_UART_PARITY_EN adds parity).
// Latency: o_uart_tx falls 2 cycles after an accepted strobe into an idle block; words stream back-to-back.
// Backpressure: o_full when FIFO_DEPTH words held; a strobe while full is dropped and sets sticky o_overflow.
module ecall_uart_tx
    import ecall_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ecall_ready,
    input  logic [31:0] i_ecall_data,
    output logic        o_full,
    output logic        o_idle,
    output logic        o_overflow,
    output logic        o_uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ, occ_nxt;
    logic [31:0]   head;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    logic [31:0]   word_reg;
    logic [1:0]    byte_idx;
    logic          word_act;

    logic          ser_vld, ser_rdy, ser_acc;
    logic          ser_idle, ser_done, ser_idle_nxt;
    logic [7:0]    ser_byte;

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == DEPTH_C);
    assign push       = i_ecall_ready && !fifo_full;

    // Byte 0 of a fresh word is handed over straight from the FIFO head so
    // the pop and the first frame start share one edge.
    assign ser_vld  = word_act || !fifo_empty;
    assign ser_byte = word_act ? word_reg[{byte_idx, 3'b000} +: 8] : head[7:0];
    assign ser_rdy  = ser_idle || ser_done;
    assign ser_acc  = ser_vld && ser_rdy;
    assign pop      = ser_acc && !word_act;

    assign ser_idle_nxt = ser_rdy && !ser_vld;
    assign occ_nxt      = occ + CW'(push) - CW'(pop);

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_ecall_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            word_reg   <= 32'd0;
            byte_idx   <= 2'd0;
            word_act   <= 1'b0;
            o_full     <= 1'b0;
            o_idle     <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            occ    <= occ_nxt;
            o_full <= (occ_nxt == DEPTH_C);
            o_idle <= (occ_nxt == '0) && ser_idle_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (i_ecall_ready && fifo_full) begin
                o_overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_reg <= head;
                byte_idx <= 2'd1;
                word_act <= 1'b1;
            end else if (ser_acc) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    word_act <= 1'b0;
                end
            end
        end
    end

    ecall_uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (ser_vld),
        .i_byte  (ser_byte),
        .o_idle  (ser_idle),
        .o_done  (ser_done),
        .o_tx    (o_uart_tx)
    );

endmodule

// File: tb/tb_ecall_uart_tx.sv
// Directed bench for ecall_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): a line decoder pops expected bytes from a scoreboard.
// Build with `ECALL_UART_PARITY_EN to exercise the 8E1 frame as well.
module tb_ecall_uart_tx;

    localparam int CPB = 4;
`ifdef ECALL_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int HALF  = CPB / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data = 32'd0;
    logic        full, idle, ovf, tx;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    int          mcnt = 0;
    bit          mbusy = 1'b0;
    logic [7:0]  mbyte = 8'd0;
    logic [7:0]  mexp = 8'd0;

    always #5 clk = ~clk;

    ecall_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ecall_ready (ready),
        .i_ecall_data  (data),
        .o_full        (full),
        .o_idle        (idle),
        .o_overflow    (ovf),
        .o_uart_tx     (tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: start detected on the first low sample, bits sampled mid-bit.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mbusy = 1'b0;
        end else if (!mbusy) begin
            if (tx === 1'b0) begin
                mbusy = 1'b1;
                mcnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt == HALF)
                chk("start_bit", {31'd0, tx}, 32'd0);
            if (mcnt >= CPB + HALF && mcnt <= 8 * CPB + HALF && (mcnt % CPB) == HALF)
                mbyte[(mcnt - CPB - HALF) / CPB] = tx;
`ifdef ECALL_UART_PARITY_EN
            if (mcnt == 9 * CPB + HALF)
                chk("parity_bit", {31'd0, tx}, {31'd0, ^mbyte});
`endif
            if (mcnt == (NBITS - 1) * CPB + HALF)
                chk("stop_bit", {31'd0, tx}, 32'd1);
            if (mcnt == FRAME - 1) begin
                mbusy = 1'b0;
                chk("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    mexp = exp_q.pop_front();
                    chk("rx_byte", {24'd0, mbyte}, {24'd0, mexp});
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic strobe(input logic [31:0] w, input bit accept);
        ready = 1'b1;
        data  = w;
        if (accept) push_word(w);
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while ((idle !== 1'b1 || exp_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_frames(input string tag, input int n_exp);
        int gaps = 0;
        chk({tag, "_frames"}, start_q.size(), n_exp);
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME) gaps++;
        chk({tag, "_gaps"}, gaps, 32'd0);
        if (start_q.size() == n_exp && n_exp > 0)
            chk({tag, "_span"}, start_q[n_exp-1] - start_q[0] + FRAME, n_exp * FRAME);
        start_q.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word: line falls two edges after the accepting edge.
        strobe(32'h4443_4241, 1'b1);
        chk("t1_idle_low", {31'd0, idle}, 32'd0);
        chk("t1_tx_e0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("t1_tx_e1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("t1_tx_e2", {31'd0, tx}, 32'd0);
        repeat (150) @(negedge clk);
        chk("t1_busy_mid", {31'd0, idle}, 32'd0);
        wait_idle("t1", 100);
        check_frames("t1", 4);

        // Five back-to-back strobes fill the FIFO (first pops); a sixth overflows.
        for (int i = 0; i < 5; i++) strobe(32'h1000_0000 + i * 32'h0102_0304, 1'b1);
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_ovf_before", {31'd0, ovf}, 32'd0);
        strobe(32'hDEAD_BEEF, 1'b0);
        chk("t2_ovf", {31'd0, ovf}, 32'd1);
        chk("t2_full_hold", {31'd0, full}, 32'd1);
        wait_idle("t2", 900);
        check_frames("t2", 20);

        pulse_reset();
        chk("t3_ovf_cleared", {31'd0, ovf}, 32'd0);

        // Strobe while full on the same edge the second word pops.
        for (int i = 0; i < 5; i++) strobe(32'h2000_00A0 + i, 1'b1);
        repeat (156) @(negedge clk);
        chk("t3_full_pre", {31'd0, full}, 32'd1);
        chk("t3_ovf_pre", {31'd0, ovf}, 32'd0);
        strobe(32'hBAD0_BAD0, 1'b0);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        chk("t3_full_after_pop", {31'd0, full}, 32'd0);
        wait_idle("t3", 800);
        check_frames("t3", 20);

        // Reset in the middle of byte 2's data bits.
        strobe(32'h3322_1100, 1'b1);
        repeat (94) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_tx", {31'd0, tx}, 32'd1);
        chk("t4_rst_idle", {31'd0, idle}, 32'd1);
        chk("t4_rst_full", {31'd0, full}, 32'd0);
        chk("t4_rst_ovf", {31'd0, ovf}, 32'd0);
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(32'h0000_00FF, 1'b1);
        wait_idle("t4", 200);
        check_frames("t4", 4);

`ifdef ECALL_UART_PARITY_EN
        strobe(32'h0000_0107, 1'b1);
        wait_idle("t5", 220);
        check_frames("t5", 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
